// File: rtl/jtag_tap_controller_if.sv
// rtl/jtag_tap_controller_if.sv - TAP pins, DR-stage handshake and decoded status bundle
interface jtag_tap_controller_if #(
    parameter int IR_WIDTH = 9
);
    logic                tms;
    logic                tdi;
    logic                dr_tdo;
    logic                tdo;
    logic                state_cdr;
    logic                state_sdr;
    logic                state_udr;
    logic                state_tlr;
    logic [IR_WIDTH-1:0] ir;

    modport master (
        output tms, tdi, dr_tdo,
        input  tdo, state_cdr, state_sdr, state_udr, state_tlr, ir
    );

    modport slave (
        input  tms, tdi, dr_tdo,
        output tdo, state_cdr, state_sdr, state_udr, state_tlr, ir
    );
endinterface

// File: rtl/jtag_tap_controller.sv
// rtl/jtag_tap_controller.sv - IEEE 1149.1 TAP state machine with instruction register
module jtag_tap_controller #(
    parameter int                  IR_WIDTH       = 9,
    parameter logic [IR_WIDTH-1:0] IR_RESET_VALUE = {IR_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    jtag_tap_controller_if.slave  jtag
);

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
    } tap_state_t;

    tap_state_t          state;
    tap_state_t          next_state;
    logic [IR_WIDTH-1:0] ir_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= TLR;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = TLR;
        case (state)
            TLR:      next_state = jtag.tms ? TLR      : RTI;
            RTI:      next_state = jtag.tms ? SEL_DR   : RTI;
            SEL_DR:   next_state = jtag.tms ? SEL_IR   : CAP_DR;
            CAP_DR:   next_state = jtag.tms ? EX1_DR   : SH_DR;
            SH_DR:    next_state = jtag.tms ? EX1_DR   : SH_DR;
            EX1_DR:   next_state = jtag.tms ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: next_state = jtag.tms ? EX2_DR   : PAUSE_DR;
            EX2_DR:   next_state = jtag.tms ? UPD_DR   : SH_DR;
            UPD_DR:   next_state = jtag.tms ? SEL_DR   : RTI;
            SEL_IR:   next_state = jtag.tms ? TLR      : CAP_IR;
            CAP_IR:   next_state = jtag.tms ? EX1_IR   : SH_IR;
            SH_IR:    next_state = jtag.tms ? EX1_IR   : SH_IR;
            EX1_IR:   next_state = jtag.tms ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: next_state = jtag.tms ? EX2_IR   : PAUSE_IR;
            EX2_IR:   next_state = jtag.tms ? UPD_IR   : SH_IR;
            UPD_IR:   next_state = jtag.tms ? SEL_DR   : RTI;
            default:  next_state = TLR;
        endcase
    end

    // Strobes decode the registered state so a DR stage sampling on the same edge acts once per visit.
    always_comb begin
        jtag.state_cdr = (state == CAP_DR);
        jtag.state_sdr = (state == SH_DR);
        jtag.state_udr = (state == UPD_DR);
        jtag.state_tlr = (state == TLR);
        jtag.tdo       = 1'b0;
        if (state == SH_IR) begin
            jtag.tdo = ir_shift[0];
        end else if (state == SH_DR) begin
            jtag.tdo = jtag.dr_tdo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_shift <= '0;
        end else if (state == CAP_IR) begin
            ir_shift <= {{(IR_WIDTH-1){1'b0}}, 1'b1};
        end else if (state == SH_IR) begin
            ir_shift <= {jtag.tdi, ir_shift[IR_WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            jtag.ir <= IR_RESET_VALUE;
        end else if (state == TLR) begin
            jtag.ir <= IR_RESET_VALUE;
        end else if (state == UPD_IR) begin
            jtag.ir <= ir_shift;
        end
    end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// tb/tb_jtag_tap_controller.sv - scoreboard bench for jtag_tap_controller
module tb_jtag_tap_controller;
    localparam int W = 9;
    localparam logic [W-1:0] RST_V = {W{1'b1}};

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    jtag_tap_controller_if #(.IR_WIDTH(W)) jif ();

    jtag_tap_controller #(.IR_WIDTH(W), .IR_RESET_VALUE(RST_V)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .jtag  (jif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         cdr, sdr, udr, tlr, tdo;
        logic [W-1:0] ir;
    } exp_t;

    exp_t         q[$];
    int           checks = 0;
    int           failures = 0;
    string        m_st = "TLR";
    int           m_sh = 0;
    logic [W-1:0] m_ir = RST_V;
    int           cdr_cnt = 0, sdr_cnt = 0, udr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic string nxt(input string s, input bit t);
        string base, xr;
        if (s == "TLR")   return t ? "TLR"   : "RTI";
        if (s == "RTI")   return t ? "SelDR" : "RTI";
        if (s == "SelDR") return t ? "SelIR" : "CapDR";
        if (s == "SelIR") return t ? "TLR"   : "CapIR";
        base = s.substr(0, s.len() - 3);
        xr   = s.substr(s.len() - 2, s.len() - 1);
        if (base == "Upd") return t ? "SelDR" : "RTI";
        if (base == "Cap" || base == "Sh") return t ? {"Ex1", xr} : {"Sh", xr};
        if (base == "Ex1")   return t ? {"Upd", xr} : {"Pause", xr};
        if (base == "Pause") return t ? {"Ex2", xr} : {"Pause", xr};
        if (base == "Ex2")   return t ? {"Upd", xr} : {"Sh", xr};
        return "TLR";
    endfunction

    function automatic void push_exp(input bit dr);
        exp_t e;
        e.cdr = (m_st == "CapDR");
        e.sdr = (m_st == "ShDR");
        e.udr = (m_st == "UpdDR");
        e.tlr = (m_st == "TLR");
        e.tdo = (m_st == "ShIR") ? m_sh[0] : ((m_st == "ShDR") ? dr : 1'b0);
        e.ir  = m_ir;
        q.push_back(e);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk("state_cdr", 32'(jif.state_cdr), 32'(e.cdr));
            chk("state_sdr", 32'(jif.state_sdr), 32'(e.sdr));
            chk("state_udr", 32'(jif.state_udr), 32'(e.udr));
            chk("state_tlr", 32'(jif.state_tlr), 32'(e.tlr));
            chk("tdo", 32'(jif.tdo), 32'(e.tdo));
            chk("ir", 32'(jif.ir), 32'(e.ir));
            chk("strobe_onehot",
                32'((32'(jif.state_cdr) + 32'(jif.state_sdr) + 32'(jif.state_udr) + 32'(jif.state_tlr)) <= 1),
                32'd1);
            if (jif.state_cdr) cdr_cnt++;
            if (jif.state_sdr) sdr_cnt++;
            if (jif.state_udr) udr_cnt++;
        end
    end

    task automatic step(input bit t, input bit d = 1'b0, input bit r = 1'b0);
        @(negedge clk);
        #1;
        jif.tms = t;
        jif.tdi = d;
        jif.dr_tdo = r;
        @(posedge clk);
        if (m_st == "TLR") m_ir = RST_V;
        if (m_st == "CapIR") m_sh = 1;
        else if (m_st == "ShIR") m_sh = (m_sh >> 1) | (int'(d) << (W - 1));
        if (m_st == "UpdIR") m_ir = m_sh[W-1:0];
        m_st = nxt(m_st, t);
        push_exp(r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_now_tlr", 32'(jif.state_tlr), 32'd1);
        chk("rst_now_ir", 32'(jif.ir), 32'(RST_V));
        chk("rst_now_tdo", 32'(jif.tdo), 32'd0);
        m_st = "TLR";
        m_sh = 0;
        m_ir = RST_V;
        push_exp(jif.dr_tdo);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic ir_scan(input logic [W-1:0] v);
        step(1); step(1); step(0); step(0);
        for (int i = 0; i < W; i++) step(i == W - 1, v[i]);
        step(1);
        step(0);
    endtask

    string paths[16];

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        jif.tms = 1'b1;
        jif.tdi = 1'b0;
        jif.dr_tdo = 1'b0;

        do_reset();
        step(0);
        #1;
        chk("rti_tlr_low", 32'(jif.state_tlr), 32'd0);
        chk("rti_ir", 32'(jif.ir), 32'h1FF);

        ir_scan(9'b1_0101_1001);
        #1;
        chk("ir_scan_159", 32'(jif.ir), 32'h159);

        cdr_cnt = 0; sdr_cnt = 0; udr_cnt = 0;
        step(1); step(0); step(0, 0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < 5; i++) step(0, 0, 1'($urandom_range(0, 1)));
        step(1, 0, 1'($urandom_range(0, 1)));
        step(1, 0, 1); step(0, 0, 1); step(0);
        chk("dr_cdr_count", 32'(cdr_cnt), 32'd1);
        chk("dr_sdr_count", 32'(sdr_cnt), 32'd6);
        chk("dr_udr_count", 32'(udr_cnt), 32'd1);

        cdr_cnt = 0; sdr_cnt = 0;
        step(1); step(0); step(0, 0, 1);
        step(1, 0, 1); step(0, 0, 1); step(0, 0, 1); step(0, 0, 1);
        step(1, 0, 1); step(0, 0, 1); step(0, 0, 1);
        step(1); step(1); step(0); step(0);
        chk("pause_cdr_count", 32'(cdr_cnt), 32'd1);
        chk("pause_sdr_count", 32'(sdr_cnt), 32'd3);

        step(1); step(1); step(0); step(0);
        for (int i = 0; i < 4; i++) step(0, 1'($urandom_range(0, 1)));
        do_reset();
        step(0);
        #1;
        chk("abort_ir", 32'(jif.ir), 32'(RST_V));

        paths = '{"", "0", "01", "010", "0100", "0101", "01010", "010101", "01011",
                  "011", "0110", "01100", "01101", "011010", "0110101", "011011"};
        foreach (paths[k]) begin
            ir_scan(W'($urandom_range(0, (1 << W) - 1)));
            for (int i = 0; i < 5; i++) step(1);
            for (int i = 0; i < paths[k].len(); i++)
                step(paths[k][i] == 8'h31, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 5; i++) step(1, 1'($urandom_range(0, 1)));
            #1;
            chk($sformatf("five_ones_tlr_%0d", k), 32'(jif.state_tlr), 32'd1);
            step(1);
            #1;
            chk($sformatf("five_ones_ir_%0d", k), 32'(jif.ir), 32'(RST_V));
        end

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 63) == 0) do_reset();
            else step($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        step(1);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
